// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and baud divider arithmetic,
// usable by both the RX and TX paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE,
        WAIT
    } rx_state_t;

    function automatic int calcDiv(input int clkFreq, input int baud, input int overSample);
        return clkFreq / (baud * overSample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle Tick every DIV clocks, phase restarted
// by Clear so the first tick lands a full DIV period after Clear drops.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] divCnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            divCnt <= '0;
            Tick   <= 1'b0;
        end else if (Clear) begin
            divCnt <= '0;
            Tick   <= 1'b0;
        end else begin
            Tick   <= (divCnt == CW'(DIV - 1));
            divCnt <= (divCnt == CW'(DIV - 1)) ? '0 : divCnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_shifter.sv
// UART receive datapath: synchronizes the line, samples each bit mid-period,
// deserializes LSB first and reports the byte or a framing error to the RX FSM.
module uart_rx_shifter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Din,
    input  logic                 EnableP,
    output logic                 Count,
    output logic [DATA_BITS-1:0] Data,
    output logic                 Valid,
    output logic                 FrameErr,
    output logic                 Busy
);

    localparam int DIV = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_t            state;
    logic                 rxMeta;
    logic                 rxSync;
    logic                 tick;
    logic [TW-1:0]        tickCnt;
    logic [BW-1:0]        bitIdx;
    logic [DATA_BITS-1:0] shiftReg;

    assign Busy = (state == START) || (state == DATA) || (state == STOP);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= Din;
            rxSync <= rxMeta;
        end
    end

    // Divider is held cleared outside an active frame so START entry sets the phase.
    uart_baud_tick #(
        .DIV(DIV)
    ) baudTick (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clear(!Busy),
        .Tick (tick)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            Data     <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Count    <= 1'b0;
        end else begin
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Count    <= 1'b0;
            case (state)
                IDLE: begin
                    tickCnt <= '0;
                    bitIdx  <= '0;
                    if (EnableP) state <= START;
                end
                START: begin
                    if (!EnableP) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (tickCnt == TW'(OVERSAMPLE / 2 - 1)) begin
                            tickCnt <= '0;
                            bitIdx  <= '0;
                            state   <= rxSync ? DONE : DATA;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (!EnableP) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (tickCnt == TW'(OVERSAMPLE - 1)) begin
                            tickCnt  <= '0;
                            shiftReg <= {rxSync, shiftReg[DATA_BITS-1:1]};
                            if (bitIdx == BW'(DATA_BITS - 1)) state <= STOP;
                            else bitIdx <= bitIdx + 1'b1;
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (!EnableP) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (tickCnt == TW'(OVERSAMPLE - 1)) begin
                            tickCnt <= '0;
                            state   <= DONE;
                            if (rxSync) begin
                                Data  <= shiftReg;
                                Valid <= 1'b1;
                            end else begin
                                FrameErr <= 1'b1;
                            end
                        end else begin
                            tickCnt <= tickCnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    Count <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!EnableP) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_shifter.md
Name: uart_rx_shifter

Overview:
Receive datapath of the full UART. It runs alongside the RX control FSM: it consumes that FSM's EnableP and returns the Count frame-done flag the FSM waits on. The block synchronizes the serial line, generates oversampled baud ticks and samples each bit at mid-period. It deserializes LSB-first data, checks the stop bit and presents the received byte with a one-cycle valid strobe.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line bit rate in bits/s
OVERSAMPLE, 16, ticks per bit; even, >= 4
DATA_BITS, 8, data bits per frame (no parity)

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Din  in  1  raw serial line, idle high, asynchronous to Clk
EnableP  in  1  from RX control FSM; high while a frame is being received or displayed
Count  out  1  frame-done flag to RX control FSM; one-cycle pulse
Data  out  DATA_BITS  last correctly received byte; held until the next good frame
Valid  out  1  one-cycle pulse, Data updated this cycle
FrameErr  out  1  one-cycle pulse, stop bit sampled low
Busy  out  1  high in START, DATA, STOP

Behaviour:
- Reset (Rst=0, async): synchronizer flops = 1, state = IDLE, counters = 0, Data = 0, Valid/FrameErr/Count = 0.
- Din passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Tick divider:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer, required >= 1.
  - One-cycle tick every DIV clocks.
  - Divider and tick counter clear on entry to START, so phase is set by frame start.
- States: IDLE, START, DATA, STOP, DONE, WAIT.
  - IDLE: EnableP=1 -> START.
  - START: after OVERSAMPLE/2 ticks, sample.
    - Sample 0 -> DATA, bit index = 0.
    - Sample 1 (glitch/false start) -> DONE without Valid.
  - DATA: every OVERSAMPLE ticks, sample and shift into the MSB of the shift register (shift right, LSB first). After DATA_BITS samples -> STOP.
  - STOP: after OVERSAMPLE ticks, sample.
    - 1: Data <= shift register, Valid=1.
    - 0: FrameErr=1, Data unchanged.
    - Either way -> DONE.
  - DONE: Count=1 for exactly one cycle -> WAIT.
  - WAIT: hold until EnableP=0 -> IDLE. This prevents re-triggering while the FSM sits in Display.
- Latency: the stop sample falls on tick 8+16*DATA_BITS+16 after START entry, which is 152 ticks for the default configuration. Valid/FrameErr register on the clock edge after that tick. Count asserts one cycle after Valid/FrameErr.
- EnableP falling while in START/DATA/STOP: abort to IDLE next cycle. No Valid, no FrameErr, no Count, Data unchanged.
- EnableP falling in DONE: Count still pulses. WAIT then exits immediately.
- Valid and FrameErr are mutually exclusive. Each is at most one pulse per frame.
- Rst asserted mid-frame: immediate return to reset values. The partial byte is discarded.
- Busy is combinational from state. All other outputs are registered.

Decomposition:
- Shared package uart_pkg: state enum typedef for rx_state_t, and a function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE. TX can reuse both.
- One natural sub-module: uart_baud_tick. It takes Clk, Rst, a clear input, and produces a tick output at the DIV rate. The same sub-module serves TX with OVERSAMPLE=1.

Test Plan:
Bench parameters: CLK_FREQ=640000, BAUD=10000, OVERSAMPLE=16, so DIV=4 and one bit = 64 clocks. The bench models the FSM: EnableP rises 1 cycle after the Din fall, and falls 1 cycle after Count.
- Send 0xA5 with good stop -> Data=8'hA5, Valid one cycle at 608+1 clocks after START entry, Count the next cycle, FrameErr never high, Busy low after STOP.
- Back-to-back 0x00 then 0xFF, with the second start 1 bit after the first stop -> two Valid pulses, Data 8'h00 then 8'hFF, two Count pulses, no frame lost.
- 0x3C with stop bit driven 0 -> FrameErr one cycle, Valid 0, Data keeps the previous value, Count pulses once.
- 20-clock low glitch on Din -> start sample reads 1, Count pulses once, Valid/FrameErr 0, block returns to IDLE after EnableP falls.
- EnableP forced low during data bit 3 -> IDLE next cycle, no Valid/FrameErr/Count. A following 0x5A frame is then received correctly.
- Rst pulled low during data bit 5, then released -> all outputs 0 immediately. A subsequent 0x81 frame gives Data=8'h81 and Valid.
